// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder: the only arithmetic in the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder cell, LSB first, one bit per clock.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry_q;
  logic             cell_s, cell_co;
  logic             accept, last_bit;

  full_adder_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture and serial shift; subtraction is A + ~B + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      a_sr    <= a_in;
      b_sr    <= sub ? ~b_in : b_in;
      carry_q <= sub | cin;
    end else if (state == RUN) begin
      cnt     <= cnt + 1'b1;
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= {cell_s, res_sr[WIDTH-1:1]};
      carry_q <= cell_co;
    end
  end

  // Result registers load on the edge entering DONE and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_out  <= '0;
      cout_out <= 1'b0;
      ovf_out  <= 1'b0;
    end else if (last_bit) begin
      sum_out  <= {cell_s, res_sr[WIDTH-1:1]};
      cout_out <= cell_co;
      ovf_out  <= carry_q ^ cell_co;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             ovf_out;

  int vectors     = 0;
  int miscompares = 0;
  int lat;
  int busy_n;
  int done_n;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out),
    .ovf_out  (ovf_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the start edge; returns at #1 after the edge that raised done.
  task automatic wait_done(input string tag, output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = busy ? 1 : 0;
    while (!done && n_edges < 40) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (busy) n_busy++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s, input logic [7:0] es,
                        input logic ec, input logic eo);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(tag, lat, busy_n);
    check({tag, "_latency"}, lat, WIDTH);
    check({tag, "_sum"}, {24'd0, sum_out}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout_out}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf_out}, {31'd0, eo});
    @(posedge clk);
    #1;
    check({tag, "_busy_cycles"}, busy_n, WIDTH + 1);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", {24'd0, sum_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_cout_ovf", {30'd0, cout_out, ovf_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_cin", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    run_op("sub_borrow", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub_cin_ign", 8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
    run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start held high while operands change: first op uses captured operands.
    @(negedge clk);
    a_in  = 8'h01;
    b_in  = 8'h02;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a_in = 8'h40;
    b_in = 8'h40;
    wait_done("hold", lat, busy_n);
    check("hold_first_sum", {24'd0, sum_out}, 32'h03);
    check("hold_latency", lat, WIDTH);
    @(posedge clk);
    #1;
    check("hold_idle_busy", {31'd0, busy}, 32'd0);
    check("hold_sum_kept", {24'd0, sum_out}, 32'h03);
    @(posedge clk);
    #1;
    check("hold_reaccept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("hold2", lat, busy_n);
    check("hold_second_sum", {24'd0, sum_out}, 32'h80);
    check("hold_second_ovf", {31'd0, ovf_out}, 32'd1);
    done_n = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) done_n++;
    end
    check("idle_no_done", done_n, 0);
    check("idle_sum_held", {24'd0, sum_out}, 32'h80);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a_in  = 8'h5A;
    b_in  = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_sum", {24'd0, sum_out}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) done_n++;
    end
    check("post_rst_quiet", done_n, 0);
    run_op("post_rst_add", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
